// File: rtl/deppmaster_if.sv
// DEPP host bus bundle: the strobe/data lines toward the peripheral plus the
// byte-stream handshake toward the local user logic.
`timescale 1ns/1ps
interface deppmaster_if;
   logic       o_astb_n;
   logic       o_dstb_n;
   logic       o_write_n;
   logic [7:0] o_depp;
   logic       o_depp_oe;
   logic [7:0] i_depp;
   logic       i_wait;
   logic       i_tx_stb;
   logic [7:0] i_tx_data;
   logic       o_tx_busy;
   logic       o_rx_stb;
   logic [6:0] o_rx_data;
   logic       o_err;

   modport master (
      output o_astb_n, o_dstb_n, o_write_n, o_depp, o_depp_oe,
      output o_tx_busy, o_rx_stb, o_rx_data, o_err,
      input  i_depp, i_wait, i_tx_stb, i_tx_data
   );

   modport slave (
      input  o_astb_n, o_dstb_n, o_write_n, o_depp, o_depp_oe,
      input  o_tx_busy, o_rx_stb, o_rx_data, o_err,
      output i_depp, i_wait, i_tx_stb, i_tx_data
   );
endinterface

// File: rtl/deppmaster.sv
// DEPP host: writes address 0 after reset, then forwards queued bytes as
// data writes and polls the peer with data reads. Bytes read with bit 7
// clear are delivered as 7-bit receive data; bit 7 set means "nothing".
`timescale 1ns/1ps
module deppmaster #(
   parameter int SETUP_CK = 2,
   parameter int GAP_CK   = 4,
   parameter int POLL_CK  = 1000,
   parameter int TMO_CK   = 255
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   deppmaster_if.master bus
);
   localparam int            PW         = $clog2(POLL_CK + 1);
   localparam logic [15:0]   SETUP_LAST = 16'(SETUP_CK - 1);
   localparam logic [15:0]   GAP_LAST   = 16'(GAP_CK - 1);
   localparam logic [7:0]    TMO_LAST   = 8'(TMO_CK - 1);
   localparam logic [PW-1:0] POLL_INIT  = PW'(POLL_CK);

   typedef enum logic [2:0] {ADDR, SETUP, STB, REL, GAP, IDLE} state_t;
   typedef enum logic [1:0] {K_ADDR, K_WRITE, K_READ} kind_t;

   state_t        state_q;
   kind_t         kind_q;
   logic          wait_s_q, wait_q;
   logic [7:0]    depp_s_q, depp_q;
   logic [15:0]   cnt_q, cnt_d;
   logic [7:0]    tmo_q, tmo_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [7:0]    rd_q;
   logic          ok_q;
   logic          astb_q, dstb_q, write_n_q, oe_q, busy_q, rx_stb_q, err_q;
   logic [7:0]    depp_o_q;
   logic [6:0]    rx_data_q;

   assign cnt_d  = cnt_q + 16'd1;
   assign tmo_d  = tmo_q + 8'd1;
   assign poll_d = (poll_q == '0) ? '0 : poll_q - PW'(1);

   assign bus.o_astb_n  = astb_q;
   assign bus.o_dstb_n  = dstb_q;
   assign bus.o_write_n = write_n_q;
   assign bus.o_depp    = depp_o_q;
   assign bus.o_depp_oe = oe_q;
   assign bus.o_tx_busy = busy_q;
   assign bus.o_rx_stb  = rx_stb_q;
   assign bus.o_rx_data = rx_data_q;
   assign bus.o_err     = err_q;

   // Bring the asynchronous wait/ack line into the clock domain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_s_q <= 1'b0;
         wait_q   <= 1'b0;
      end else begin
         wait_s_q <= bus.i_wait;
         wait_q   <= wait_s_q;
      end
   end

   // Bus data synchronizer; same depth as wait so data and ack line up.
   always_ff @(posedge i_clk) begin
      depp_s_q <= bus.i_depp;
      depp_q   <= depp_s_q;
   end

   // Transaction sequencer with registered bus outputs and poll timer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ADDR;
         kind_q    <= K_ADDR;
         cnt_q     <= '0;
         tmo_q     <= '0;
         poll_q    <= POLL_INIT;
         rd_q      <= '0;
         ok_q      <= 1'b0;
         astb_q    <= 1'b1;
         dstb_q    <= 1'b1;
         write_n_q <= 1'b1;
         depp_o_q  <= '0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b1;
         rx_stb_q  <= 1'b0;
         rx_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         rx_stb_q <= 1'b0;
         err_q    <= 1'b0;
         poll_q   <= poll_d;
         case (state_q)
            ADDR: begin
               depp_o_q  <= 8'h00;
               oe_q      <= 1'b1;
               write_n_q <= 1'b0;
               kind_q    <= K_ADDR;
               cnt_q     <= '0;
               state_q   <= SETUP;
            end
            SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  if (kind_q == K_ADDR) astb_q <= 1'b0;
                  else                  dstb_q <= 1'b0;
                  tmo_q   <= '0;
                  state_q <= STB;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            STB: begin
               if (wait_q) begin
                  if (kind_q == K_READ) rd_q <= depp_q;
                  astb_q  <= 1'b1;
                  dstb_q  <= 1'b1;
                  tmo_q   <= tmo_d;
                  state_q <= REL;
               end else if (tmo_q == TMO_LAST) begin
                  // Peer never acknowledged: abandon the transfer.
                  astb_q    <= 1'b1;
                  dstb_q    <= 1'b1;
                  write_n_q <= 1'b1;
                  oe_q      <= 1'b0;
                  err_q     <= 1'b1;
                  ok_q      <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= GAP;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            REL: begin
               if (!wait_q) begin
                  write_n_q <= 1'b1;
                  oe_q      <= 1'b0;
                  ok_q      <= 1'b1;
                  cnt_q     <= '0;
                  if (kind_q == K_READ) poll_q <= POLL_INIT;
                  state_q   <= GAP;
               end else if (tmo_q == TMO_LAST) begin
                  // Peer held wait too long after the strobe rose.
                  write_n_q <= 1'b1;
                  oe_q      <= 1'b0;
                  err_q     <= 1'b1;
                  ok_q      <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= GAP;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  if (kind_q == K_ADDR && !ok_q) begin
                     state_q <= ADDR;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
                  if (kind_q == K_READ && ok_q && !rd_q[7]) begin
                     rx_stb_q  <= 1'b1;
                     rx_data_q <= rd_q[6:0];
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            IDLE: begin
               if (bus.i_tx_stb && !busy_q) begin
                  depp_o_q  <= bus.i_tx_data;
                  oe_q      <= 1'b1;
                  write_n_q <= 1'b0;
                  busy_q    <= 1'b1;
                  kind_q    <= K_WRITE;
                  cnt_q     <= '0;
                  state_q   <= SETUP;
               end else if (poll_q == '0) begin
                  write_n_q <= 1'b1;
                  oe_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  kind_q    <= K_READ;
                  cnt_q     <= '0;
                  state_q   <= SETUP;
               end
            end
            default: state_q <= ADDR;
         endcase
      end
   end
endmodule

// File: tb/tb_deppmaster.sv
// Bench for deppmaster: a peer model answers strobes, a scoreboard queue
// holds expected bus/rx/err events, and a monitor pops them as they occur.
`timescale 1ns/1ps
module tb_deppmaster;
   localparam int SETUP_CK = 2;
   localparam int GAP_CK   = 4;
   localparam int POLL_CK  = 1000;
   localparam int TMO_CK   = 255;
   localparam int ACK_DLY  = 3;

   localparam logic [2:0] EV_ADDR = 3'd0;
   localparam logic [2:0] EV_WR   = 3'd1;
   localparam logic [2:0] EV_RD   = 3'd2;
   localparam logic [2:0] EV_RX   = 3'd3;
   localparam logic [2:0] EV_ERR  = 3'd4;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   deppmaster_if bus();

   deppmaster #(
      .SETUP_CK(SETUP_CK), .GAP_CK(GAP_CK), .POLL_CK(POLL_CK), .TMO_CK(TMO_CK)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .bus    (bus)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [10:0] exp_q[$];
   int rd_falls[$];
   int rx_count     = 0;
   int last_low     = 0;
   int astb_rise    = 0;
   int wr_rise      = 0;
   logic       ack_en  = 1'b1;
   logic [7:0] peer_rd = 8'h35;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic sb_pop(input logic [2:0] k, input logic [7:0] d);
      logic [10:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL sb_unexpected: actual kind %0d data 0x%02h, required no event", k, d);
      end else begin
         e = exp_q.pop_front();
         if (e !== {k, d}) begin
            n_bad++;
            $display("FAIL sb_event: actual kind %0d data 0x%02h, required kind %0d data 0x%02h",
                     k, d, e[10:8], e[7:0]);
         end
      end
   endtask

   // Peer model: raise wait ACK_DLY cycles after a strobe falls, drop it when released.
   initial begin
      int ack_cnt;
      ack_cnt = 0;
      bus.i_wait = 1'b0;
      bus.i_depp = 8'h00;
      forever begin
         @(negedge i_clk);
         if (!bus.o_astb_n || !bus.o_dstb_n) begin
            if (ack_en) begin
               if (ack_cnt >= ACK_DLY - 1) begin
                  bus.i_wait = 1'b1;
                  if (bus.o_write_n) bus.i_depp = peer_rd;
               end else begin
                  ack_cnt++;
               end
            end
         end else begin
            ack_cnt = 0;
            bus.i_wait = 1'b0;
         end
      end
   end

   // Monitor: turns DUT activity into events and checks bus rules each cycle.
   initial begin
      logic p_astb, p_dstb, p_wn;
      logic [7:0] p_depp;
      int stable, low_cnt;
      p_astb = 1'b1; p_dstb = 1'b1; p_wn = 1'b1; p_depp = 8'h00;
      stable = 0; low_cnt = 0;
      forever begin
         @(negedge i_clk);
         if (bus.o_write_n !== p_wn || bus.o_depp !== p_depp) stable = 0;
         else stable++;
         if (p_astb && !bus.o_astb_n) begin
            sb_pop(EV_ADDR, bus.o_depp);
            chk("setup_astb", int'(stable >= SETUP_CK), 1);
         end
         if (p_dstb && !bus.o_dstb_n) begin
            if (bus.o_write_n) begin
               sb_pop(EV_RD, 8'h00);
               rd_falls.push_back(cyc);
            end else begin
               sb_pop(EV_WR, bus.o_depp);
            end
            chk("setup_dstb", int'(stable >= SETUP_CK), 1);
         end
         if (!p_astb && bus.o_astb_n) astb_rise = cyc;
         if (!p_dstb && bus.o_dstb_n && !bus.o_write_n) wr_rise = cyc;
         if (!bus.o_dstb_n) low_cnt++;
         else if (!p_dstb) begin
            last_low = low_cnt;
            low_cnt  = 0;
         end
         if (bus.o_rx_stb) begin
            rx_count++;
            sb_pop(EV_RX, {1'b0, bus.o_rx_data});
         end
         if (bus.o_err) sb_pop(EV_ERR, 8'h00);
         if (!bus.o_astb_n && !bus.o_dstb_n) chk("both_strobes_low", 1, 0);
         if (bus.o_depp_oe && bus.o_write_n) chk("oe_while_read", 1, 0);
         p_astb = bus.o_astb_n; p_dstb = bus.o_dstb_n;
         p_wn   = bus.o_write_n; p_depp = bus.o_depp;
      end
   end

   task automatic wait_busy_low(input int bound, input string name);
      int n;
      n = 0;
      while (bus.o_tx_busy !== 1'b0 && n < bound) begin
         @(negedge i_clk);
         n++;
      end
      chk(name, int'(bus.o_tx_busy), 0);
   endtask

   task automatic wait_drain(input int bound, input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge i_clk);
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic send_tx(input logic [7:0] d);
      @(negedge i_clk);
      bus.i_tx_stb  = 1'b1;
      bus.i_tx_data = d;
      @(negedge i_clk);
      bus.i_tx_stb  = 1'b0;
      chk("busy_after_accept", int'(bus.o_tx_busy), 1);
   endtask

   // Directed scenario sequence.
   initial begin
      int t1, t2, pred, n;
      bus.i_tx_stb  = 1'b0;
      bus.i_tx_data = 8'h00;
      repeat (3) @(negedge i_clk);

      chk("rst_astb_n",  int'(bus.o_astb_n), 1);
      chk("rst_dstb_n",  int'(bus.o_dstb_n), 1);
      chk("rst_write_n", int'(bus.o_write_n), 1);
      chk("rst_depp",    int'(bus.o_depp), 0);
      chk("rst_oe",      int'(bus.o_depp_oe), 0);
      chk("rst_busy",    int'(bus.o_tx_busy), 1);
      chk("rst_rx_stb",  int'(bus.o_rx_stb), 0);
      chk("rst_rx_data", int'(bus.o_rx_data), 0);
      chk("rst_err",     int'(bus.o_err), 0);

      // Address write after reset release.
      exp_q.push_back({EV_ADDR, 8'h00});
      i_rst_n = 1'b1;
      wait_busy_low(200, "busy_after_addr");
      chk("busy_fall_after_gap", int'((cyc - astb_rise) >= GAP_CK), 1);
      wait_drain(10, "drain_addr");

      // Data write of 0x41, then the first poll returns 0x35.
      exp_q.push_back({EV_WR, 8'h41});
      exp_q.push_back({EV_RD, 8'h00});
      exp_q.push_back({EV_RX, 8'h35});
      send_tx(8'h41);
      wait_drain(3000, "drain_poll_35");
      t1 = (rd_falls.size() > 0) ? rd_falls[0] : 0;

      // Next poll returns 0xFF: a read with no delivery.
      peer_rd = 8'hFF;
      exp_q.push_back({EV_RD, 8'h00});
      wait_drain(3000, "drain_poll_ff");
      repeat (30) @(negedge i_clk);
      chk("no_rx_on_ff", rx_count, 1);
      t2 = (rd_falls.size() > 1) ? rd_falls[1] : t1;

      // Write request held in the cycle the poll falls due: write goes first.
      peer_rd = 8'h22;
      pred = t2 + (t2 - t1);
      exp_q.push_back({EV_WR, 8'h5A});
      exp_q.push_back({EV_RD, 8'h00});
      exp_q.push_back({EV_RX, 8'h22});
      n = 0;
      while (cyc < pred - 3 && n < 3000) begin
         @(negedge i_clk);
         n++;
      end
      bus.i_tx_stb  = 1'b1;
      bus.i_tx_data = 8'h5A;
      @(negedge i_clk);
      bus.i_tx_stb  = 1'b0;
      chk("busy_after_collide", int'(bus.o_tx_busy), 1);
      wait_drain(300, "drain_collide");
      chk("collide_read_after_gap",
          int'(rd_falls.size() > 2 && (rd_falls[2] - wr_rise) >= GAP_CK + SETUP_CK), 1);

      // Peer never acknowledges: timeout, error pulse, byte dropped.
      wait_busy_low(50, "busy_before_tmo");
      ack_en = 1'b0;
      exp_q.push_back({EV_WR, 8'h7E});
      exp_q.push_back({EV_ERR, 8'h00});
      send_tx(8'h7E);
      wait_drain(400, "drain_timeout");
      chk("tmo_strobe_low_cycles", last_low, TMO_CK);
      ack_en = 1'b1;
      wait_busy_low(50, "idle_after_tmo");
      repeat (20) @(negedge i_clk);

      // Reset while the data strobe is low.
      ack_en = 1'b0;
      exp_q.push_back({EV_WR, 8'h11});
      send_tx(8'h11);
      n = 0;
      while (bus.o_dstb_n !== 1'b0 && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      chk("dstb_low_before_rst", int'(bus.o_dstb_n), 0);
      repeat (5) @(negedge i_clk);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("async_rst_dstb_n",  int'(bus.o_dstb_n), 1);
      chk("async_rst_astb_n",  int'(bus.o_astb_n), 1);
      chk("async_rst_oe",      int'(bus.o_depp_oe), 0);
      chk("async_rst_write_n", int'(bus.o_write_n), 1);
      exp_q.push_back({EV_ADDR, 8'h00});
      ack_en = 1'b1;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wait_busy_low(200, "busy_after_rst");
      wait_drain(10, "drain_readdr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
